// File: rtl/dpram_port_master_if.sv
// Client and RAM-pin bundle for dpram_port_master.
//   master modport : the burst initiator (drives req_ready, write/read streams, RAM pins)
//   slave modport  : the client + RAM side (drives requests, write beats, mem_dout)
// Signals:
//   req_valid/req_ready/req_wr/req_addr/req_len : burst request handshake
//   wdata/wdata_valid/wdata_ready               : write beat stream
//   rdata/rdata_valid                           : read beat stream (no backpressure)
//   done                                        : one-cycle burst completion pulse
//   mem_addr/mem_din/mem_wr_en/mem_en_n/mem_dout: RAM port pins (en active-low)
interface dpram_port_master_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_len;

  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;

  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  done;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_wr_en;
  logic                  mem_en_n;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    input  req_valid, req_wr, req_addr, req_len,
    input  wdata, wdata_valid,
    input  mem_dout,
    output req_ready, wdata_ready,
    output rdata, rdata_valid, done,
    output mem_addr, mem_din, mem_wr_en, mem_en_n
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_len,
    output wdata, wdata_valid,
    output mem_dout,
    input  req_ready, wdata_ready,
    input  rdata, rdata_valid, done,
    input  mem_addr, mem_din, mem_wr_en, mem_en_n
  );

endinterface

// File: rtl/dpram_port_master.sv
// Burst initiator for one port of the dual-port RAM (active-low enable,
// wr_en=1 write, one-cycle registered read latency).
// Ports:
//   clk_A : clock, rising edge
//   rst_A : asynchronous active-low reset
//   bus   : dpram_port_master_if.master (request, write stream, read stream,
//           done pulse, RAM pins)
// Write bursts: one RAM write per accepted wdata beat, pins registered the
// cycle after acceptance. Read bursts: one read per cycle, the first one
// registered on the request-acceptance edge, data returned two cycles later.
module dpram_port_master #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                clk_A,
  input  logic                rst_A,
  dpram_port_master_if.master bus
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   cur_addr, cur_addr_d;
  logic [AW-1:0]   rem, rem_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            mem_en_n_q, mem_en_n_d;
  logic            mem_wr_en_q, mem_wr_en_d;
  logic            req_ready_q, req_ready_d;
  logic            done_q, done_d;
  logic            rd_issue_d;
  logic [1:0]      rd_pipe;
  logic [DW-1:0]   rdata_q;
  logic            rdata_valid_q;
  logic            accept_c;
  logic            beat_c;

  assign accept_c = bus.req_valid & req_ready_q & (state == IDLE);
  assign beat_c   = bus.wdata_valid & (state == WRITE);

  // Next-state and next-pin logic; rem counts beats still to issue after the current one.
  always_comb begin
    state_d     = state;
    cur_addr_d  = cur_addr;
    rem_d       = rem;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_en_n_d  = 1'b1;
    mem_wr_en_d = 1'b0;
    done_d      = 1'b0;
    rd_issue_d  = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          rem_d = bus.req_len;
          if (bus.req_wr) begin
            state_d    = WRITE;
            cur_addr_d = bus.req_addr;
          end else begin
            // First read goes out on the acceptance edge so data returns in cycle 3.
            state_d    = READ;
            mem_en_n_d = 1'b0;
            mem_addr_d = bus.req_addr;
            cur_addr_d = bus.req_addr + AW'(1);
            rd_issue_d = 1'b1;
          end
        end
      end

      WRITE: begin
        if (beat_c) begin
          mem_en_n_d  = 1'b0;
          mem_wr_en_d = 1'b1;
          mem_addr_d  = cur_addr;
          mem_din_d   = bus.wdata;
          cur_addr_d  = cur_addr + AW'(1);
          if (rem == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d = rem - AW'(1);
          end
        end
      end

      READ: begin
        if (rem == '0) begin
          state_d = RD_DRAIN;
        end else begin
          mem_en_n_d = 1'b0;
          mem_addr_d = cur_addr;
          cur_addr_d = cur_addr + AW'(1);
          rem_d      = rem - AW'(1);
          rd_issue_d = 1'b1;
        end
      end

      RD_DRAIN: begin
        // Last read data is captured on this edge; done lines up with its rdata_valid.
        if (!rd_pipe[0]) begin
          state_d = IDLE;
          done_d  = rd_pipe[1];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready only after a full cycle back in IDLE, so it trails done by one cycle.
    req_ready_d = (state == IDLE) && (state_d == IDLE);
  end

  // Control state and RAM pin registers.
  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      state       <= IDLE;
      cur_addr    <= '0;
      rem         <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_en_n_q  <= 1'b1;
      mem_wr_en_q <= 1'b0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      cur_addr    <= cur_addr_d;
      rem         <= rem_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_en_n_q  <= mem_en_n_d;
      mem_wr_en_q <= mem_wr_en_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
    end
  end

  // Read-return pipeline: stage 0 = read on pins, stage 1 = RAM output valid.
  always_ff @(posedge clk_A or negedge rst_A) begin
    if (!rst_A) begin
      rd_pipe       <= 2'b00;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rd_pipe       <= {rd_pipe[0], rd_issue_d};
      rdata_valid_q <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rdata_q <= bus.mem_dout;
      end
    end
  end

  assign bus.wdata_ready = (state == WRITE);
  assign bus.req_ready   = req_ready_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.mem_en_n    = mem_en_n_q;
  assign bus.mem_wr_en   = mem_wr_en_q;

endmodule

// File: tb/tb_dpram_port_master.sv
// Testbench for dpram_port_master: a behavioural RAM on the pin side and an
// address-indexed expected-contents array updated from the bursts the bench issues.
module tb_dpram_port_master;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;

  logic clk_A = 1'b0;
  logic rst_A = 1'b1;

  always #5 clk_A = ~clk_A;

  dpram_port_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dpram_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_A (clk_A),
    .rst_A (rst_A),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Physical RAM: one-cycle registered read, X on the output when not reading.
  logic [DW-1:0] ram [0:DEPTH-1];
  int            wr_count = 0;

  always @(posedge clk_A) begin
    if (!bus.mem_en_n) begin
      if (bus.mem_wr_en) begin
        ram[bus.mem_addr] = bus.mem_din;
        wr_count = wr_count + 1;
        bus.mem_dout <= 'x;
      end else begin
        bus.mem_dout <= ram[bus.mem_addr];
      end
    end else begin
      bus.mem_dout <= 'x;
    end
  end

  // Expected RAM contents and per-burst stimulus.
  logic [DW-1:0] exp_mem [0:DEPTH-1];
  logic [DW-1:0] wr_data [0:DEPTH-1];
  bit            vpat    [0:255];
  int            vpat_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_A);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en_n"},   32'(bus.mem_en_n),    32'(1'b1));
    check({tag, "_wr_en"},  32'(bus.mem_wr_en),   32'(1'b0));
    check({tag, "_addr"},   32'(bus.mem_addr),    32'(0));
    check({tag, "_din"},    32'(bus.mem_din),     32'(0));
    check({tag, "_rdata"},  32'(bus.rdata),       32'(0));
    check({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'(1'b0));
    check({tag, "_done"},   32'(bus.done),        32'(1'b0));
    check({tag, "_ready"},  32'(bus.req_ready),   32'(1'b0));
  endtask

  task automatic wait_ready();
    int g = 0;
    while (bus.req_ready !== 1'b1 && g < 64) begin
      tick();
      g++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'(1'b1));
  endtask

  // Write burst of len+1 beats from wr_data[], wdata_valid per cycle from vpat[].
  task automatic do_write(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int            n;
    int            beat;
    int            cyc;
    bit            v;
    logic [AW-1:0] a;
    n = int'(len) + 1;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
    check("wr_busy_ready", 32'(bus.req_ready), 32'(1'b0));
    beat = 0;
    cyc  = 0;
    while (beat < n && cyc < 400) begin
      check("wr_wdata_ready", 32'(bus.wdata_ready), 32'(1'b1));
      v = (cyc < vpat_len) ? vpat[cyc] : 1'b1;
      bus.wdata_valid = v;
      bus.wdata       = wr_data[beat];
      tick();
      if (v) begin
        a = addr + AW'(beat);
        check("wr_en_n",  32'(bus.mem_en_n),  32'(1'b0));
        check("wr_wr_en", 32'(bus.mem_wr_en), 32'(1'b1));
        check("wr_addr",  32'(bus.mem_addr),  32'(a));
        check("wr_din",   32'(bus.mem_din),   32'(wr_data[beat]));
        check("wr_done",  32'(bus.done),      32'(beat == n - 1));
        exp_mem[a] = wr_data[beat];
        beat++;
      end else begin
        check("wr_gap_en_n", 32'(bus.mem_en_n), 32'(1'b1));
        check("wr_gap_done", 32'(bus.done),     32'(1'b0));
      end
      cyc++;
    end
    bus.wdata_valid = 1'b0;
    check("wr_beats_issued", 32'(beat), 32'(n));
    check("wr_done_cycle_ready", 32'(bus.req_ready),   32'(1'b0));
    check("wr_done_cycle_wrdy",  32'(bus.wdata_ready), 32'(1'b0));
    tick();
    check("wr_after_ready", 32'(bus.req_ready), 32'(1'b1));
    check("wr_after_done",  32'(bus.done),      32'(1'b0));
    check("wr_after_en_n",  32'(bus.mem_en_n),  32'(1'b1));
  endtask

  // Read burst: addresses in cycles 1..n, data in 3..n+2, done in n+2.
  task automatic do_read(input logic [AW-1:0] addr, input logic [AW-1:0] len);
    int            n;
    logic [AW-1:0] a;
    n = int'(len) + 1;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = len;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      if (k == 1) begin
        check("rd_busy_ready", 32'(bus.req_ready),   32'(1'b0));
        check("rd_wdata_rdy",  32'(bus.wdata_ready), 32'(1'b0));
      end
      if (k <= n) begin
        a = addr + AW'(k - 1);
        check("rd_en_n",  32'(bus.mem_en_n),  32'(1'b0));
        check("rd_wr_en", 32'(bus.mem_wr_en), 32'(1'b0));
        check("rd_addr",  32'(bus.mem_addr),  32'(a));
      end else begin
        check("rd_tail_en_n", 32'(bus.mem_en_n), 32'(1'b1));
      end
      check("rd_valid", 32'(bus.rdata_valid), 32'(k >= 3));
      if (k >= 3) begin
        a = addr + AW'(k - 3);
        check("rd_data", 32'(bus.rdata), 32'(exp_mem[a]));
      end
      check("rd_done", 32'(bus.done), 32'(k == n + 2));
      tick();
    end
    check("rd_after_ready", 32'(bus.req_ready),   32'(1'b1));
    check("rd_after_valid", 32'(bus.rdata_valid), 32'(1'b0));
    check("rd_after_done",  32'(bus.done),        32'(1'b0));
  endtask

  initial begin
    int            wc0;
    logic [AW-1:0] ra;
    logic [AW-1:0] rl;

    bus.req_valid   = 1'b0;
    bus.req_wr      = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata       = '0;
    bus.wdata_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]     = DW'($urandom);
      exp_mem[i] = ram[i];
    end

    // Asynchronous reset before any clock edge.
    #1 rst_A = 1'b0;
    #2 check_reset_values("rst0");
    tick();
    tick();
    rst_A = 1'b1;
    check("rst0_ready_held", 32'(bus.req_ready), 32'(1'b0));
    tick();
    check("rst0_ready_rise", 32'(bus.req_ready), 32'(1'b1));

    // Write then read the same range.
    wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_data[2] = 8'h33; wr_data[3] = 8'h44;
    vpat_len = 0;
    do_write(AW'(3), AW'(3));
    do_read(AW'(3), AW'(3));

    // Wrap from 31 to 0.
    for (int i = 0; i < 4; i++) wr_data[i] = DW'(8'hA0 + i);
    do_write(AW'(30), AW'(3));
    do_read(AW'(31), AW'(1));

    // Write stalls: 3 beats over valid pattern 1,0,0,1,1.
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1; vpat[4] = 1'b1;
    vpat_len = 5;
    for (int i = 0; i < 3; i++) wr_data[i] = DW'(8'h5A + 7 * i);
    wc0 = wr_count;
    do_write(AW'(12), AW'(2));
    check("stall_ram_writes", 32'(wr_count - wc0), 32'(3));
    vpat_len = 0;

    // Full-depth write of value = address, then full-depth read.
    for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = DW'(i);
    do_write(AW'(0), AW'(31));
    do_read(AW'(0), AW'(31));

    // Reset mid-burst: 2 of 4 beats reach the RAM before reset.
    for (int i = 0; i < 4; i++) wr_data[i] = DW'(8'hB0 + i);
    for (int i = 8; i < 12; i++) exp_mem[i] = DW'(8'hC0 + i);
    vpat_len = 0;
    do_write(AW'(8), AW'(3));
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = AW'(8);
    bus.req_len   = AW'(3);
    tick();
    bus.req_valid   = 1'b0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = wr_data[0];
    tick();
    bus.wdata = wr_data[1];
    tick();
    bus.wdata = wr_data[2];
    tick();
    check("mid_third_beat_addr", 32'(bus.mem_addr), 32'(10));
    exp_mem[8] = wr_data[0];
    exp_mem[9] = wr_data[1];
    #3 rst_A = 1'b0;
    #1 check_reset_values("rst_mid");
    bus.wdata_valid = 1'b0;
    tick();
    check("rst_mid_no_done", 32'(bus.done),     32'(1'b0));
    check("rst_mid_idle",    32'(bus.mem_en_n), 32'(1'b1));
    tick();
    rst_A = 1'b1;
    check("rst_mid_ready_held", 32'(bus.req_ready), 32'(1'b0));
    tick();
    check("rst_mid_ready_rise", 32'(bus.req_ready), 32'(1'b1));
    do_read(AW'(8), AW'(3));

    // Randomized write bursts with random stalls, each followed by a random read.
    for (int it = 0; it < 12; it++) begin
      ra = AW'($urandom);
      rl = (it % 4 == 3) ? AW'($urandom_range(16, 31)) : AW'($urandom_range(0, 7));
      for (int i = 0; i < int'(DEPTH); i++) wr_data[i] = DW'($urandom);
      for (int i = 0; i < 64; i++) vpat[i] = ($urandom_range(0, 3) != 0);
      vpat_len = 64;
      do_write(ra, rl);
      vpat_len = 0;
      do_read(ra + AW'($urandom_range(0, 3)), AW'($urandom_range(0, 9)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
